sprite_line_scheduler: RTL and testbench
========================================

Name: sprite_line_scheduler

Overview:
- Per-scanline sprite scheduler between the sprite register array/decoder and the sprite line renderer.
- On each line start it walks all sprites in ascending index order and checks each one's enable bit, vertical position and decoded height against the target line.
- For every sprite that covers the line, it hands the renderer a (sprite index, row within sprite) pair over a valid/ready handshake.
- Caps work per line at MAX_PER_LINE and flags overflow.

Parameters:
- NUM_SPRITES, 64, number of sprites scanned per line
- INDEX_WIDTH, 6, width of sprite index; 2**INDEX_WIDTH >= NUM_SPRITES
- LINE_WIDTH, 10, width of unsigned scanline number
- MAX_PER_LINE, 16, maximum hits emitted per line (1..NUM_SPRITES)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- line_start  in  1  one-cycle pulse: begin scheduling line `line`
- line  in  LINE_WIDTH  target scanline, sampled when line_start=1
- spr_index  out  INDEX_WIDTH  sprite currently addressed in the register array
- spr_enabled  in  1  decoded CTRL0 enable of sprite spr_index, combinational, same cycle
- spr_vshift  in  2  decoded VSIZE field; height = 8 << spr_vshift (8/16/32/64)
- spr_y  in  LINE_WIDTH+1  signed two's-complement top Y of sprite spr_index
- out_valid  out  1  hit entry available
- out_sprite  out  INDEX_WIDTH  index of hit sprite
- out_row  out  6  row inside sprite (line - spr_y)
- out_ready  in  1  renderer accepts entry
- busy  out  1  scan in progress (any state but IDLE)
- scan_done  out  1  one-cycle pulse at end of a completed line scan
- overflow  out  1  set at scan end if more than MAX_PER_LINE sprites hit the line; held until next line_start
- hit_count  out  $clog2(MAX_PER_LINE+1)  entries emitted for current/last line

Behaviour:
- Reset (async, asserted) state:
  - state=IDLE.
  - All outputs 0: spr_index, out_valid, out_sprite, out_row, busy, scan_done, overflow, hit_count.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - On line_start, latch line into line_q, clear hit_count and overflow, set spr_index=0, go to SCAN.
- SCAN, one sprite per cycle, evaluated combinationally from spr_* inputs:
  - diff = {1'b0,line_q} - spr_y, computed at LINE_WIDTH+2 bits signed.
  - hit = spr_enabled && diff >= 0 && diff < (8 << spr_vshift).
  - hit and hit_count < MAX_PER_LINE: register out_sprite=spr_index and out_row=diff[5:0], set out_valid, go to EMIT.
  - hit and hit_count == MAX_PER_LINE: set overflow, go to DONE. Remaining sprites are not examined.
  - No hit, spr_index == NUM_SPRITES-1: go to DONE.
  - No hit, otherwise: spr_index+1, stay in SCAN.
- EMIT:
  - out_valid held with out_sprite/out_row stable until out_ready=1.
  - On the accept cycle: out_valid->0 and hit_count+1. If spr_index == NUM_SPRITES-1 go to DONE; else spr_index+1 and go to SCAN.
  - out_ready while out_valid=0 is ignored.
- DONE: scan_done=1 for exactly this cycle, then IDLE. spr_index holds its last value.
- Latency:
  - line_start to first SCAN evaluation: 1 cycle.
  - A miss costs 1 cycle.
  - A hit costs 1 cycle plus the EMIT cycles; minimum 2 cycles with out_ready held high.
- line_start while busy (any state but IDLE):
  - Abort: out_valid->0 immediately with no entry accepted, no scan_done for the aborted line.
  - Restart at spr_index=0 with the new line; hit_count and overflow cleared.
- line_start in the DONE cycle: scan_done still pulses, and the new scan starts.
- Order is strictly ascending index, so lower index wins under the cap.
- A spr_y change during the scan affects only sprites not yet evaluated.

Test Plan:
- Single-sprite hit, rows 9 through 15 (sprite 3 enabled, y=10, vshift=1, line=25, out_ready=1): exactly one entry, out_sprite=3, out_row=15, hit_count=1. scan_done pulses NUM_SPRITES+2 cycles after line_start.
- Top and bottom edges, rows 16 through 24 (y=10, vshift=0): line=17 gives out_row=7; line=18 gives no entry; line=10 gives out_row=0; line=9 gives no entry. Disabled sprite at the same y gives no entry.
- Negative Y clipping, rows 25 through 32 (spr_y=-5, vshift=2 so height 32): line=0 gives out_row=5; line=26 gives out_row=31; line=27 gives no entry.
- Cap and overflow, rows 33 through 40 (20 sprites, indices 0..19, all covering line 100; MAX_PER_LINE=16): entries are indices 0..15 in order. overflow=1 and hit_count=16 at scan_done. Index 16 is never output.
- Backpressure, rows 41 through 46 (two hits with out_ready low for 5 cycles on the first):
  - out_valid/out_sprite/out_row remain stable.
  - spr_index does not advance.
  - Second entry follows after the accept.
- Abort, rows 47 through 52 (line_start for line 50 issued while EMIT is stalled on line 40):
  - out_valid drops the next cycle and no scan_done occurs for line 40.
  - Rescan from index 0 yields the line-50 entries.
  - Async reset asserted mid-scan clears all outputs immediately.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: walks all sprites in index order on each line
// start and hands (sprite, row) pairs for covering sprites to the line renderer.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES  = 64,
  parameter int INDEX_WIDTH  = 6,
  parameter int LINE_WIDTH   = 10,
  parameter int MAX_PER_LINE = 16,
  localparam int CW          = $clog2(MAX_PER_LINE + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   line_start,
  input  logic [LINE_WIDTH-1:0]  line,
  output logic [INDEX_WIDTH-1:0] spr_index,
  input  logic                   spr_enabled,
  input  logic [1:0]             spr_vshift,
  input  logic [LINE_WIDTH:0]    spr_y,
  output logic                   out_valid,
  output logic [INDEX_WIDTH-1:0] out_sprite,
  output logic [5:0]             out_row,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   scan_done,
  output logic                   overflow,
  output logic [CW-1:0]          hit_count
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_SPRITES - 1);
  localparam logic [CW-1:0]          CAP        = CW'(MAX_PER_LINE);

  state_t                  state_r, state_s;
  logic [LINE_WIDTH-1:0]   line_r, line_s;
  logic [INDEX_WIDTH-1:0]  index_s, sprite_s;
  logic [5:0]              row_s;
  logic                    valid_s, overflow_s;
  logic [CW-1:0]           count_s;
  logic signed [LINE_WIDTH+1:0] diff_s;
  logic [LINE_WIDTH+1:0]   height_s;
  logic                    hit_s;

  // Vertical coverage test of the currently addressed sprite against the latched line.
  always_comb begin
    diff_s = $signed({2'b00, line_r}) - $signed({spr_y[LINE_WIDTH], spr_y});
    case (spr_vshift)
      2'd0:    height_s = (LINE_WIDTH+2)'(8);
      2'd1:    height_s = (LINE_WIDTH+2)'(16);
      2'd2:    height_s = (LINE_WIDTH+2)'(32);
      2'd3:    height_s = (LINE_WIDTH+2)'(64);
      default: height_s = (LINE_WIDTH+2)'(8);
    endcase
    hit_s = spr_enabled && !diff_s[LINE_WIDTH+1] && ($unsigned(diff_s) < height_s);
  end

  // Next-state and next-output logic; a line_start in any state restarts the scan.
  always_comb begin
    state_s    = state_r;
    line_s     = line_r;
    index_s    = spr_index;
    sprite_s   = out_sprite;
    row_s      = out_row;
    valid_s    = out_valid;
    overflow_s = overflow;
    count_s    = hit_count;
    if (line_start) begin
      state_s    = SCAN;
      line_s     = line;
      index_s    = {INDEX_WIDTH{1'b0}};
      valid_s    = 1'b0;
      overflow_s = 1'b0;
      count_s    = {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        SCAN: begin
          if (hit_s) begin
            if (hit_count < CAP) begin
              sprite_s = spr_index;
              row_s    = diff_s[5:0];
              valid_s  = 1'b1;
              state_s  = EMIT;
            end else begin
              overflow_s = 1'b1;
              state_s    = DONE;
            end
          end else if (spr_index == LAST_INDEX) begin
            state_s = DONE;
          end else begin
            index_s = spr_index + INDEX_WIDTH'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            valid_s = 1'b0;
            count_s = hit_count + CW'(1);
            if (spr_index == LAST_INDEX) begin
              state_s = DONE;
            end else begin
              index_s = spr_index + INDEX_WIDTH'(1);
              state_s = SCAN;
            end
          end else begin
            state_s = EMIT;
          end
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State and registered outputs; busy/scan_done track the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      line_r     <= {LINE_WIDTH{1'b0}};
      spr_index  <= {INDEX_WIDTH{1'b0}};
      out_valid  <= 1'b0;
      out_sprite <= {INDEX_WIDTH{1'b0}};
      out_row    <= 6'd0;
      busy       <= 1'b0;
      scan_done  <= 1'b0;
      overflow   <= 1'b0;
      hit_count  <= {CW{1'b0}};
    end else begin
      state_r    <= state_s;
      line_r     <= line_s;
      spr_index  <= index_s;
      out_valid  <= valid_s;
      out_sprite <= sprite_s;
      out_row    <= row_s;
      busy       <= (state_s != IDLE);
      scan_done  <= (state_s == DONE);
      overflow   <= overflow_s;
      hit_count  <= count_s;
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler: directed edge cases plus
// randomized sprite tables checked against a list-based reference model.
module tb_sprite_line_scheduler;
  localparam int N   = 64;
  localparam int IW  = 6;
  localparam int LW  = 10;
  localparam int MAX = 16;
  localparam int CW  = $clog2(MAX + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, line_start, spr_enabled, out_ready;
  logic [LW-1:0]  line;
  logic [IW-1:0]  spr_index, out_sprite;
  logic [1:0]     spr_vshift;
  logic [LW:0]    spr_y;
  logic           out_valid, busy, scan_done, overflow;
  logic [5:0]     out_row;
  logic [CW-1:0]  hit_count;

  logic              en_tab [N];
  logic [1:0]        vs_tab [N];
  logic signed [LW:0] y_tab [N];

  int checks = 0;
  int failures = 0;
  int exp_idx[$];
  int exp_row[$];
  bit exp_ovf;

  sprite_line_scheduler #(.NUM_SPRITES(N), .INDEX_WIDTH(IW), .LINE_WIDTH(LW), .MAX_PER_LINE(MAX)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line(line),
    .spr_index(spr_index), .spr_enabled(spr_enabled), .spr_vshift(spr_vshift), .spr_y(spr_y),
    .out_valid(out_valid), .out_sprite(out_sprite), .out_row(out_row), .out_ready(out_ready),
    .busy(busy), .scan_done(scan_done), .overflow(overflow), .hit_count(hit_count)
  );

  // Sprite register array model addressed by the scheduler.
  always_comb begin
    spr_enabled = en_tab[spr_index];
    spr_vshift  = vs_tab[spr_index];
    spr_y       = y_tab[spr_index];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tab();
    for (int i = 0; i < N; i++) begin
      en_tab[i] = 1'b0; vs_tab[i] = 2'd0; y_tab[i] = '0;
    end
  endtask

  task automatic set_spr(input int i, input bit en, input int vs, input int y);
    en_tab[i] = en; vs_tab[i] = 2'(vs); y_tab[i] = (LW+1)'(y);
  endtask

  // Reference: list of covering sprites in index order, capped, with overflow.
  task automatic build_exp(input int ln);
    exp_idx.delete(); exp_row.delete(); exp_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = ln - int'(y_tab[i]);
      if (en_tab[i] && d >= 0 && d < (8 << vs_tab[i])) begin
        if (exp_idx.size() == MAX) begin
          exp_ovf = 1'b1;
          break;
        end
        exp_idx.push_back(i);
        exp_row.push_back(d);
      end
    end
  endtask

  task automatic start_line(input int ln);
    build_exp(ln);
    line_start = 1'b1;
    line = LW'(ln);
  endtask

  // Follows one scan to scan_done, accepting entries and comparing with the model.
  task automatic monitor(input int ready_mode, input int stall_first, input int exp_cycles);
    int cyc, got, stall_left;
    bit done, pv, pr;
    logic [IW-1:0] ps, pidx;
    logic [5:0] prow;
    cyc = 0; got = 0; done = 0; pv = 0; pr = 0; stall_left = stall_first;
    ps = '0; pidx = '0; prow = '0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      line_start = 1'b0;
      cyc++;
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sprite", out_sprite, ps);
        chk("hold_row", out_row, prow);
        chk("hold_index", spr_index, pidx);
      end
      if (out_valid) begin
        if (!(pv && !pr)) begin
          if (got < exp_idx.size()) begin
            chk("entry_sprite", out_sprite, exp_idx[got]);
            chk("entry_row", out_row, exp_row[got]);
          end else begin
            chk("extra_entry", got, exp_idx.size());
          end
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else if (ready_mode == 1) begin
          out_ready = 1'($urandom_range(0, 1));
        end else begin
          out_ready = 1'b1;
        end
        if (out_ready) got++;
      end else begin
        out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      pv = out_valid; pr = out_ready; ps = out_sprite; prow = out_row; pidx = spr_index;
      if (scan_done) begin
        done = 1'b1;
        chk("entry_total", got, exp_idx.size());
        chk("overflow", overflow, exp_ovf);
        chk("hit_count", hit_count, exp_idx.size());
        if (exp_cycles > 0) chk("scan_latency", cyc, exp_cycles);
      end
    end
    chk("scan_done_seen", done, 1);
  endtask

  task automatic run_line(input int ln, input int ready_mode, input int stall_first, input int exp_cycles);
    start_line(ln);
    monitor(ready_mode, stall_first, exp_cycles);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_index"}, spr_index, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_sprite"}, out_sprite, 0);
    chk({tag, "_row"}, out_row, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, scan_done, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_count"}, hit_count, 0);
  endtask

  initial begin
    int base, waited;
    reset = 1'b1; line_start = 1'b0; line = '0; out_ready = 1'b1;
    clear_tab();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Single sprite hit, bottom row of a 16-high sprite; latency to scan_done.
    set_spr(3, 1, 1, 10);
    run_line(25, 0, 0, N + 2);

    // Top and bottom edges of an 8-high sprite, then disabled.
    set_spr(3, 1, 0, 10);
    run_line(17, 0, 0, 0);
    run_line(18, 0, 0, 0);
    run_line(10, 0, 0, 0);
    run_line(9, 0, 0, 0);
    set_spr(3, 0, 0, 10);
    run_line(12, 0, 0, 0);

    // Negative Y clipping with a 32-high sprite.
    clear_tab();
    set_spr(5, 1, 2, -5);
    run_line(0, 0, 0, 0);
    run_line(26, 0, 0, 0);
    run_line(27, 0, 0, 0);

    // Cap and overflow: 20 sprites all covering line 100.
    clear_tab();
    for (int i = 0; i < 20; i++) set_spr(i, 1, 1, 90);
    run_line(100, 0, 0, 0);
    chk("cap_ovf_const", exp_ovf, 1);

    // Backpressure: first of two entries stalled five cycles.
    clear_tab();
    set_spr(5, 1, 0, 58);
    set_spr(9, 1, 1, 50);
    run_line(60, 0, 5, 0);

    // Abort: new line_start while EMIT is stalled.
    clear_tab();
    set_spr(2, 1, 1, 35);
    set_spr(7, 1, 0, 45);
    start_line(40);
    out_ready = 1'b0;
    waited = 0;
    @(negedge clk);
    line_start = 1'b0;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("abort_stall_valid", out_valid, 1);
    repeat (3) @(negedge clk);
    start_line(50);
    @(negedge clk);
    line_start = 1'b0;
    chk("abort_valid_drop", out_valid, 0);
    chk("abort_index", spr_index, 0);
    chk("abort_busy", busy, 1);
    chk("abort_no_done", scan_done, 0);
    monitor(0, 0, 0);

    // Randomized sprite tables, random backpressure.
    for (int t = 0; t < 8; t++) begin
      base = $urandom_range(0, 1023);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) set_spr(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 1100) - 70);
        else set_spr(i, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), base - $urandom_range(0, 70));
      end
      run_line(base, 1, 0, 0);
    end

    // Asynchronous reset in the middle of a scan.
    start_line(base);
    out_ready = 1'b0;
    @(negedge clk);
    line_start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    run_line(base, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
